lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Upstream feeder for the LCD pulse/enable stage. Accepts byte writes (char or command)
//  from the processor, queues them, runs the HD44780 power-on init sequence, then issues
//  each byte downstream as a 1-cycle nonzero strobe. Enforces per-command execution delays
//  so the processor never polls LCD busy.
// PARAMETERS
//  FIFO_DEPTH      16       queue entries (power of 2, >=2)
//  POWERUP_CYC     750000   wait after reset before first init byte (15 ms @ 50 MHz)
//  SHORT_WAIT_CYC  2500     post-issue wait, normal cmds/chars (50 us); must be >=8
//  LONG_WAIT_CYC   100000   post-issue wait, clear/home (2 ms)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  wr_en          in   1  write request, 1-cycle qualifier
//  wr_data        in   8  byte to write; 0x00 is never enqueued (dropped silently)
//  wr_rs          in   1  0 = command, 1 = character data
//  full           out  1  FIFO full; writes while high are dropped
//  overflow       out  1  sticky: set on any dropped write while full
//  busy           out  1  high unless state==IDLE and FIFO empty
//  init_done      out  1  high once init table fully issued and last wait elapsed
//  lcd_cmd_data   out  8  to LCD stage dataa: byte for exactly 1 cycle, else 0x00
//  lcd_cmd_rs     out  1  to LCD stage datab: rs of last issued byte, held until next issue
// BEHAVIOUR
//  Reset (async): all outputs 0, FIFO empty, ptrs/count 0, wait counter 0, state PWRUP.
//  FSM: PWRUP -> INIT_ISSUE -> INIT_WAIT -> (next init | IDLE) ; IDLE -> ISSUE -> WAIT -> IDLE.
//   PWRUP: count POWERUP_CYC cycles, then INIT_ISSUE with init index 0.
//   INIT_ISSUE: drive table[idx] (rs=0) for 1 cycle. Table: 0x38,0x0C,0x01,0x06.
//   INIT_WAIT: wait per rule below; idx<3 -> idx+1, INIT_ISSUE; idx==3 -> init_done=1, IDLE.
//   IDLE: FIFO nonempty -> pop head, ISSUE next cycle; else stay.
//   ISSUE: lcd_cmd_data=byte, lcd_cmd_rs=rs for this cycle (registered outputs); -> WAIT.
//   WAIT: count wait cycles, lcd_cmd_data=0x00; on expiry -> IDLE (next pop earliest then).
//  Wait rule: rs==0 and byte in {0x01,0x02,0x03} -> LONG_WAIT_CYC; else SHORT_WAIT_CYC.
//   Counter loads N-1 on ISSUE, expires at 0: exactly N cycles between consecutive strobes
//   measured strobe-end to next strobe-start +1 (strobe spacing = N+1 cycles min incl. IDLE).
//  Strobe rule: lcd_cmd_data nonzero for exactly one cycle per byte; never two adjacent
//   nonzero cycles (downstream restarts its enable pulse on nonzero).
//  FIFO: writes accepted in every state including PWRUP/init; order preserved.
//   Write+pop same cycle: pop uses old head; write accepted iff full==0 before the cycle
//   (full evaluated pre-pop). Count width clog2(FIFO_DEPTH)+1; pointers wrap mod depth.
//  overflow cleared only by reset. wr_en with wr_data==0x00 neither enqueues nor sets overflow.
//  Reset mid-operation: strobe/wait aborted, queue flushed, init restarts from PWRUP.
// STRUCTURE
//  Shared include lcd_defs.vh: FSM state localparams, init table bytes (0x38,0x0C,0x01,0x06),
//   CLEAR/HOME opcode constants used by wait rule.
//  Sub-module lcd_cmd_fifo (9-bit wide {rs,data}, DEPTH param, push/pop/full/empty, async reset).
//  Top: FSM + wait counter + init index + output registers.
// TESTING (bench overrides POWERUP_CYC=20, SHORT_WAIT_CYC=10, LONG_WAIT_CYC=40, DEPTH=4)
//  Reset release, no writes -> strobes 0x38,0x0C,0x01,0x06 rs=0; first at cycle 21 after
//   release; spacing 11/11/41 cycles; init_done rises 11 cycles after 0x06 strobe.
//  Write 'H'(0x48,rs=1),'i'(0x69,rs=1) during PWRUP -> issued only after init, in order,
//   lcd_cmd_rs=1 held between strobes, spacing 11.
//  After init write cmd 0x01 then char 0x41 -> strobe gap 41 cycles; then 0x41 rs=1.
//  Fill 4 entries while in WAIT, 5th write -> full=1, 5th dropped, overflow=1 stays set;
//   simultaneous pop+write when full -> write dropped, count 3.
//  wr_data=0x00 write -> no enqueue, no strobe, overflow unchanged.
//  Assert reset during LONG wait with 3 queued -> outputs 0, full=0, busy=1, init restarts,
//   queued bytes never appear.

Source files
------------

// File: rtl/lcd_cmd_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lcd_cmd_sequencer_pkg
// Brief   : FSM states, HD44780 init table and wait-class helpers.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package lcd_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PWRUP      = 3'd0,
    S_INIT_ISSUE = 3'd1,
    S_INIT_WAIT  = 3'd2,
    S_IDLE       = 3'd3,
    S_ISSUE      = 3'd4,
    S_WAIT       = 3'd5
  } state_t;

  localparam logic [7:0] c_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] c_CMD_HOME     = 8'h02;
  localparam logic [7:0] c_CMD_HOME_ALT = 8'h03;
  localparam logic [1:0] c_INIT_LAST    = 2'd3;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and home are the only slow instructions; character data never is.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return !rs && ((data == c_CMD_CLEAR) || (data == c_CMD_HOME) || (data == c_CMD_HOME_ALT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_sequencer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lcd_cmd_sequencer_fifo
// Brief   : Show-ahead FIFO of {rs,data} entries with async reset.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module lcd_cmd_sequencer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full is judged before this cycle's pop, so a push into a full queue is lost.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lcd_cmd_sequencer
// Brief   : Queues LCD bytes, runs HD44780 init, strobes bytes with exec delays.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module lcd_cmd_sequencer
  import lcd_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int POWERUP_CYC    = 750000,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] lcd_cmd_data,
  output logic       lcd_cmd_rs
);

  localparam int c_MAX_A   = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int c_MAX_CYC = (c_MAX_A > SHORT_WAIT_CYC) ? c_MAX_A : SHORT_WAIT_CYC;
  localparam int c_CW      = $clog2(c_MAX_CYC + 1);

  localparam logic [c_CW-1:0] c_PWRUP_LAST = c_CW'(POWERUP_CYC - 1);
  localparam logic [c_CW-1:0] c_SHORT_LOAD = c_CW'(SHORT_WAIT_CYC - 1);
  localparam logic [c_CW-1:0] c_LONG_LOAD  = c_CW'(LONG_WAIT_CYC - 1);

  function automatic logic [c_CW-1:0] wait_load(input logic rs, input logic [7:0] data);
    return needs_long_wait(rs, data) ? c_LONG_LOAD : c_SHORT_LOAD;
  endfunction

  state_t          r_state;
  logic [c_CW-1:0] r_wait;
  logic [1:0]      r_init_idx;
  logic            w_wr_valid;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [8:0]      w_head;

  assign w_wr_valid = wr_en && (wr_data != 8'h00);
  assign w_pop      = (r_state == S_IDLE) && !w_fifo_empty;
  assign full       = w_fifo_full;
  assign busy       = !((r_state == S_IDLE) && w_fifo_empty);

  lcd_cmd_sequencer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_wr_valid),
    .i_pop   (w_pop),
    .i_data  ({wr_rs, wr_data}),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Queued bytes pass through IDLE between waits, so their ISSUE state also
  // counts down; init bytes go straight back to INIT_ISSUE and hold instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_PWRUP;
      r_wait       <= '0;
      r_init_idx   <= '0;
      lcd_cmd_data <= 8'h00;
      lcd_cmd_rs   <= 1'b0;
      init_done    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      lcd_cmd_data <= 8'h00;
      if (w_wr_valid && w_fifo_full) overflow <= 1'b1;

      case (r_state)
        S_PWRUP: begin
          if (r_wait == c_PWRUP_LAST) begin
            r_state      <= S_INIT_ISSUE;
            r_init_idx   <= 2'd0;
            lcd_cmd_data <= init_byte(2'd0);
            lcd_cmd_rs   <= 1'b0;
            r_wait       <= wait_load(1'b0, init_byte(2'd0));
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_INIT_ISSUE: r_state <= S_INIT_WAIT;
        S_INIT_WAIT: begin
          if (r_wait == '0) begin
            if (r_init_idx == c_INIT_LAST) begin
              r_state   <= S_IDLE;
              init_done <= 1'b1;
            end else begin
              r_state      <= S_INIT_ISSUE;
              r_init_idx   <= r_init_idx + 2'd1;
              lcd_cmd_data <= init_byte(r_init_idx + 2'd1);
              lcd_cmd_rs   <= 1'b0;
              r_wait       <= wait_load(1'b0, init_byte(r_init_idx + 2'd1));
            end
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_IDLE: begin
          if (!w_fifo_empty) begin
            r_state      <= S_ISSUE;
            lcd_cmd_data <= w_head[7:0];
            lcd_cmd_rs   <= w_head[8];
            r_wait       <= wait_load(w_head[8], w_head[7:0]);
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_wait  <= r_wait - 1'b1;
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_IDLE;
          else              r_wait  <= r_wait - 1'b1;
        end
        default: r_state <= S_PWRUP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_lcd_cmd_sequencer
// Brief   : Randomized bench against a time-scheduled model of the sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_cmd_sequencer;

  localparam int P  = 20;
  localparam int NS = 10;
  localparam int NL = 40;
  localparam int D  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_rs = 1'b0;
  logic       full, overflow, busy, init_done, lcd_cmd_rs;
  logic [7:0] lcd_cmd_data;

  lcd_cmd_sequencer #(
    .FIFO_DEPTH     (D),
    .POWERUP_CYC    (P),
    .SHORT_WAIT_CYC (NS),
    .LONG_WAIT_CYC  (NL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_rs        (wr_rs),
    .full         (full),
    .overflow     (overflow),
    .busy         (busy),
    .init_done    (init_done),
    .lcd_cmd_data (lcd_cmd_data),
    .lcd_cmd_rs   (lcd_cmd_rs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int gcyc  = 0;
  int strobe_t [256];

  // Model: a queue of pending bytes plus the times at which strobes may happen.
  logic [8:0] mq [$];
  bit         m_ovf, m_done;
  logic       m_rs;
  int         m_ready;
  int         m_init_t [4];
  int         m_done_t;
  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int wait_of(logic rs, logic [7:0] b);
    return (!rs && b >= 8'h01 && b <= 8'h03) ? NL : NS;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_done = 0; m_rs = 1'b0; m_ready = 0;
    m_init_t[0] = P;
    for (int k = 1; k < 4; k++) m_init_t[k] = m_init_t[k-1] + wait_of(1'b0, init_tab[k-1]) + 1;
    m_done_t = m_init_t[3] + wait_of(1'b0, init_tab[3]) + 1;
  endtask

  initial begin
    logic [7:0] exp_data;
    logic [8:0] item;
    bit         popped;
    int         pre;
    forever begin
      @(negedge clk);
      gcyc++;
      if (reset) begin
        model_reset();
        t = 0;
        check("rst_data", lcd_cmd_data, 8'h00);
        check("rst_rs", lcd_cmd_rs, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_done", init_done, 1'b0);
        check("rst_busy", busy, 1'b1);
      end else begin
        t++;
        exp_data = 8'h00;
        popped = 0;
        pre = mq.size();
        for (int k = 0; k < 4; k++)
          if (t == m_init_t[k]) begin exp_data = init_tab[k]; m_rs = 1'b0; end
        if (t == m_done_t) begin m_done = 1; m_ready = t; end
        if (m_done && t > m_ready && pre > 0) begin
          item = mq.pop_front();
          exp_data = item[7:0];
          m_rs = item[8];
          m_ready = t + wait_of(item[8], item[7:0]);
          popped = 1;
        end
        if (wr_en && wr_data != 8'h00) begin
          if (pre < D) mq.push_back({wr_rs, wr_data});
          else m_ovf = 1;
        end
        check("data", lcd_cmd_data, exp_data);
        check("rs", lcd_cmd_rs, m_rs);
        check("full", full, (mq.size() == D));
        check("overflow", overflow, m_ovf);
        check("init_done", init_done, m_done);
        check("busy", busy, !(m_done && t >= m_ready && !popped && mq.size() == 0));
        if (t == 19) check("pin_t19", lcd_cmd_data, 8'h00);
        if (t == 20) check("pin_t20", lcd_cmd_data, 8'h38);
        if (t == 31) check("pin_t31", lcd_cmd_data, 8'h0C);
        if (t == 42) check("pin_t42", lcd_cmd_data, 8'h01);
        if (t == 83) check("pin_t83", lcd_cmd_data, 8'h06);
        if (t == 93) check("pin_done93", init_done, 1'b0);
        if (t == 94) check("pin_done94", init_done, 1'b1);
        if (lcd_cmd_data != 8'h00) strobe_t[lcd_cmd_data] = gcyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(logic [7:0] d, logic rs);
    wr_en = 1'b1; wr_data = d; wr_rs = rs;
    tick();
    wr_en = 1'b0; wr_data = 8'h00; wr_rs = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", maxc);
    end
  endtask

  initial begin
    int         r;
    int         a_before;
    logic [7:0] d;
    logic       rs;

    repeat (3) tick();
    reset = 1'b0;

    // Writes during power-up wait are held until init completes.
    repeat (3) tick();
    wr(8'h48, 1'b1);
    repeat (2) tick();
    wr(8'h69, 1'b1);
    wait_idle(400);
    check("gap_H_i", strobe_t[8'h69] - strobe_t[8'h48], 11);
    check("rs_held", lcd_cmd_rs, 1'b1);

    // Clear followed by a character: long gap.
    wr(8'h01, 1'b0);
    wr(8'h41, 1'b1);
    wait_idle(400);
    check("gap_clr_A", strobe_t[8'h41] - strobe_t[8'h01], 41);

    // Fill during a long wait, overflow, then pop+write while full.
    wr(8'h02, 1'b0);
    for (int k = 0; k < 5; k++) wr(8'h50 + 8'(k), 1'b1);
    check("fill_full", full, 1'b1);
    check("fill_ovf", overflow, 1'b1);
    for (int k = 0; k < 60; k++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'($urandom_range(0, 15)); wr_rs = 1'b1;
      tick();
    end
    wr_en = 1'b0; wr_data = 8'h00; wr_rs = 1'b0;
    wait_idle(1000);

    // Zero bytes are ignored entirely.
    wr(8'h00, 1'b0);
    wr(8'h00, 1'b1);
    wr(8'h00, 1'b0);
    repeat (3) tick();
    check("zero_busy", busy, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 9);
        rs = 1'b1;
        if (r == 0) d = 8'h00;
        else if (r == 1) begin d = 8'($urandom_range(1, 3)); rs = 1'b0; end
        else begin d = 8'($urandom_range(0, 255)); rs = 1'($urandom_range(0, 1)); end
        wr_en = 1'b1; wr_data = d; wr_rs = rs;
      end else begin
        wr_en = 1'b0; wr_data = 8'h00; wr_rs = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0; wr_data = 8'h00; wr_rs = 1'b0;
    wait_idle(2000);

    // Reset in the middle of a long wait with three bytes queued.
    wr(8'h01, 1'b0);
    wr(8'h61, 1'b1);
    wr(8'h62, 1'b1);
    wr(8'h63, 1'b1);
    a_before = strobe_t[8'h61];
    repeat (8) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_data", lcd_cmd_data, 8'h00);
    check("mid_rst_full", full, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_ovf", overflow, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    wait_idle(400);
    repeat (20) tick();
    check("flushed_a", strobe_t[8'h61], a_before);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
